// File: rtl/dsp_vacc.sv
// Multi-channel vector accumulator: sums N_CHAN interleaved channels over acc_len frames.
// Optional macro DSP_VACC_SAT_EN makes overflowing sums saturate instead of wrapping.
module dsp_vacc #(
  parameter int unsigned N_CHAN    = 4,
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned LEN_WIDTH = 16,
  parameter string       IS_SIGNED = "TRUE"
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ce,
  input  logic [IN_WIDTH-1:0]       din,
  input  logic                      sync,
  input  logic [LEN_WIDTH-1:0]      acc_len,
  output logic [OUT_WIDTH-1:0]      dout,
  output logic [$clog2(N_CHAN)-1:0] dout_chan,
  output logic                      dout_vld,
  output logic                      dout_last,
  output logic                      ovf
);

  localparam int unsigned CW  = $clog2(N_CHAN);
  localparam int unsigned MSB = OUT_WIDTH - 1;
  localparam bit          SGN = (IS_SIGNED == "TRUE");

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CW-1:0]        chan;
  logic [LEN_WIDTH-1:0] frm;
  logic [LEN_WIDTH-1:0] len_r;
  logic [OUT_WIDTH-1:0] acc [N_CHAN];

  logic                 s1_vld;
  logic [OUT_WIDTH-1:0] s1_din;
  logic [OUT_WIDTH-1:0] s1_acc;
  logic [CW-1:0]        s1_chan;
  logic                 s1_first;
  logic                 s1_last;

  // Position of the sample on din: sync forces channel 0 of frame 0 with a fresh length
  logic                 take;
  logic [CW-1:0]        cur_chan;
  logic [LEN_WIDTH-1:0] cur_frm;
  logic [LEN_WIDTH-1:0] cur_len;
  logic                 chan_wrap;
  logic [OUT_WIDTH-1:0] ext_din;

  always_comb begin
    take      = ce && (sync || (state == RUN));
    cur_chan  = sync ? '0 : chan;
    cur_frm   = sync ? '0 : frm;
    cur_len   = len_r;
    if (sync) cur_len = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
    chan_wrap = (cur_chan == CW'(N_CHAN - 1));
    if (SGN) ext_din = OUT_WIDTH'($signed(din));
    else     ext_din = OUT_WIDTH'(din);
  end

  // S2 adder with overflow detection (and saturation when enabled)
  logic [OUT_WIDTH-1:0] acc_op;
  logic [OUT_WIDTH:0]   raw;
  logic [OUT_WIDTH-1:0] sum;
  logic                 s2_ov;

  always_comb begin
    acc_op = s1_first ? '0 : s1_acc;
    raw    = {1'b0, acc_op} + {1'b0, s1_din};
    if (SGN) s2_ov = (acc_op[MSB] == s1_din[MSB]) && (raw[MSB] != acc_op[MSB]);
    else     s2_ov = raw[OUT_WIDTH];
    sum = raw[OUT_WIDTH-1:0];
`ifdef DSP_VACC_SAT_EN
    if (s2_ov) begin
      if (SGN) sum = acc_op[MSB] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else     sum = '1;
    end
`endif
  end

  // Accumulator RAM holds no reset; every run starts with a first-frame overwrite
  always_ff @(posedge clk) begin
    if (ce && s1_vld) acc[s1_chan] <= sum;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      chan      <= '0;
      frm       <= '0;
      len_r     <= '0;
      s1_vld    <= 1'b0;
      s1_din    <= '0;
      s1_acc    <= '0;
      s1_chan   <= '0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      dout      <= '0;
      dout_chan <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      if (ce) begin
        if (take) begin
          state <= RUN;
          len_r <= cur_len;
          chan  <= chan_wrap ? '0 : cur_chan + CW'(1);
          if (chan_wrap) frm <= (cur_frm == cur_len - LEN_WIDTH'(1)) ? '0 : cur_frm + LEN_WIDTH'(1);
          else           frm <= cur_frm;
        end
        s1_vld   <= take;
        s1_din   <= ext_din;
        s1_chan  <= cur_chan;
        s1_first <= (cur_frm == '0);
        s1_last  <= (cur_frm == cur_len - LEN_WIDTH'(1));
        // Write-first: the address being written by S2 this edge is read back as the new sum
        s1_acc   <= (s1_vld && (s1_chan == cur_chan)) ? sum : acc[cur_chan];
        if (s1_vld && s1_last) begin
          dout      <= sum;
          dout_chan <= s1_chan;
          dout_vld  <= 1'b1;
          dout_last <= (s1_chan == CW'(N_CHAN - 1));
        end
        if (sync)                 ovf <= 1'b0;
        else if (s1_vld && s2_ov) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dsp_vacc.sv
// Scoreboard bench for dsp_vacc: signed/32, unsigned/32 and signed/17 instances share one stimulus.
module tb_dsp_vacc;

  logic        clk = 1'b0;
  logic        rst_n, ce, sync;
  logic [15:0] din, acc_len;

  logic [31:0] d0, d1;
  logic [16:0] d2;
  logic [1:0]  ch0, ch1, ch2;
  logic        vld0, vld1, vld2, lst0, lst1, lst2, ovf0, ovf1, ovf2;

  always #5 clk = ~clk;

  dsp_vacc #(.N_CHAN(4), .IN_WIDTH(16), .OUT_WIDTH(32), .LEN_WIDTH(16), .IS_SIGNED("TRUE")) u0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .sync(sync), .acc_len(acc_len),
    .dout(d0), .dout_chan(ch0), .dout_vld(vld0), .dout_last(lst0), .ovf(ovf0));
  dsp_vacc #(.N_CHAN(4), .IN_WIDTH(16), .OUT_WIDTH(32), .LEN_WIDTH(16), .IS_SIGNED("FALSE")) u1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .sync(sync), .acc_len(acc_len),
    .dout(d1), .dout_chan(ch1), .dout_vld(vld1), .dout_last(lst1), .ovf(ovf1));
  dsp_vacc #(.N_CHAN(4), .IN_WIDTH(16), .OUT_WIDTH(17), .LEN_WIDTH(16), .IS_SIGNED("TRUE")) u2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .sync(sync), .acc_len(acc_len),
    .dout(d2), .dout_chan(ch2), .dout_vld(vld2), .dout_last(lst2), .ovf(ovf2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] v0;
    logic [31:0] v1;
    logic [16:0] v2;
    int          chan;
    bit          last;
    bit          o0, o1, o2;
  } exp_t;

  exp_t   q[$];
  longint a0[4], a1[4], a2[4];
  bit     m_run, mo0, mo1, mo2;
  int     m_chan, m_frm, m_len;
  bit     toggle_mode = 1'b0;
  bit     prev_vld    = 1'b0;

  // Reference add in unbounded integers, then wrap or saturate into w bits
  task automatic acc_step(input longint a, input longint e, input int w, input bit sgn,
                          output longint r, output bit ov);
    longint m, hi, lo;
    m = longint'(1) << w;
    if (sgn) begin hi = m / 2 - 1; lo = -(m / 2); end
    else     begin hi = m - 1;     lo = 0;        end
    r  = a + e;
    ov = (r > hi) || (r < lo);
    if (ov) begin
`ifdef DSP_VACC_SAT_EN
      r = (r > hi) ? hi : lo;
`else
      r = (r > hi) ? r - m : r + m;
`endif
    end
  endtask

  task automatic model_step(input logic [15:0] d, input bit s);
    longint es, eu, r;
    bit     ov, first, last;
    exp_t   e;
    if (s) begin
      m_run = 1'b1; m_chan = 0; m_frm = 0;
      m_len = (acc_len == 16'd0) ? 1 : int'(acc_len);
      mo0 = 1'b0; mo1 = 1'b0; mo2 = 1'b0;
    end else if (!m_run) begin
      return;
    end
    es    = longint'($signed(d));
    eu    = longint'(d);
    first = (m_frm == 0);
    last  = (m_frm == m_len - 1);
    acc_step(first ? 0 : a0[m_chan], es, 32, 1'b1, r, ov); a0[m_chan] = r; mo0 |= ov;
    acc_step(first ? 0 : a1[m_chan], eu, 32, 1'b0, r, ov); a1[m_chan] = r; mo1 |= ov;
    acc_step(first ? 0 : a2[m_chan], es, 17, 1'b1, r, ov); a2[m_chan] = r; mo2 |= ov;
    if (last) begin
      e.v0 = 32'(a0[m_chan]); e.v1 = 32'(a1[m_chan]); e.v2 = 17'(a2[m_chan]);
      e.chan = m_chan; e.last = (m_chan == 3);
      e.o0 = mo0; e.o1 = mo1; e.o2 = mo2;
      q.push_back(e);
    end
    m_chan++;
    if (m_chan == 4) begin
      m_chan = 0;
      m_frm++;
      if (m_frm == m_len) m_frm = 0;
    end
  endtask

  logic [31:0] cap0[4], cap1[4];
  logic [16:0] cap2[4];
  bit          capo0[4], capo2[4];

  // Scoreboard: every valid output pops one expected result
  always @(negedge clk) begin
    exp_t e;
    if (vld0 || vld1 || vld2) begin
      if (toggle_mode) check("vld_width", 64'(prev_vld), 64'd0);
      if (q.size() == 0) begin
        check("unexpected_vld", 64'(vld0), 64'd0);
      end else begin
        e = q.pop_front();
        check("vld_u0", 64'(vld0), 64'd1);
        check("vld_u1", 64'(vld1), 64'd1);
        check("vld_u2", 64'(vld2), 64'd1);
        check("dout_u0", 64'(d0), 64'(e.v0));
        check("chan_u0", 64'(ch0), 64'(e.chan));
        check("last_u0", 64'(lst0), 64'(e.last));
        check("ovf_u0", 64'(ovf0), 64'(e.o0));
        check("dout_u1", 64'(d1), 64'(e.v1));
        check("ovf_u1", 64'(ovf1), 64'(e.o1));
        check("dout_u2", 64'(d2), 64'(e.v2));
        check("ovf_u2", 64'(ovf2), 64'(e.o2));
        cap0[ch0] = d0; cap1[ch0] = d1; cap2[ch0] = d2;
        capo0[ch0] = ovf0; capo2[ch0] = ovf2;
      end
    end
    prev_vld = vld0;
  end

  task automatic sample(input logic [15:0] d, input bit s);
    @(posedge clk); #1;
    ce = 1'b1; din = d; sync = s;
    model_step(d, s);
    if (toggle_mode) begin
      @(posedge clk); #1;
      ce = 1'b0; sync = 1'b0; din = 16'($urandom);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ce = 1'b0; sync = 1'b0; din = 16'($urandom);
    end
  endtask

  // mode 0: din = chan + base; mode 1: din = base on every channel
  task automatic run_burst(input logic [15:0] len, input int frames, input bit mode,
                           input logic [15:0] base);
    acc_len = len;
    for (int f = 0; f < frames; f++)
      for (int c = 0; c < 4; c++)
        sample(mode ? base : 16'(c) + base, (f == 0) && (c == 0));
    sample(16'd0, 1'b0);
    idle(3);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n = 1'b0; ce = 1'b0; sync = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    m_run = 1'b0;
    q.delete();
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b0; sync = 1'b0; din = '0; acc_len = 16'd3;
    m_run = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_dout", 64'(d0), 64'd0);
    check("rst_vld", 64'(vld0), 64'd0);
    check("rst_chan", 64'(ch0), 64'd0);
    check("rst_last", 64'(lst0), 64'd0);
    check("rst_ovf", 64'(ovf0), 64'd0);

    // samples before the first sync are ignored
    for (int i = 0; i < 6; i++) sample(16'(i + 50), 1'b0);
    idle(2);

    // test 1: din = chan+1 over 3 frames
    run_burst(16'd3, 3, 1'b0, 16'd1);
    check("t1_c0", 64'(cap0[0]), 64'd3);
    check("t1_c1", 64'(cap0[1]), 64'd6);
    check("t1_c2", 64'(cap0[2]), 64'd9);
    check("t1_c3", 64'(cap0[3]), 64'd12);
    check("t1_ovf", 64'(capo0[3]), 64'd0);

    // test 2: all-ones input, signed vs unsigned extension
    run_burst(16'd4, 4, 1'b1, 16'hFFFF);
    check("t2_signed", 64'(cap0[2]), 64'hFFFF_FFFC);
    check("t2_unsigned", 64'(cap1[2]), 64'h0003_FFFC);

    // test 3: 17-bit signed accumulator overflow
    run_burst(16'd4, 4, 1'b1, 16'h7FFF);
`ifdef DSP_VACC_SAT_EN
    check("t3_dout17", 64'(cap2[1]), 64'h0FFFF);
`else
    check("t3_dout17", 64'(cap2[1]), 64'h1FFFC);
`endif
    check("t3_ovf17", 64'(capo2[1]), 64'd1);
    check("t3_dout32", 64'(cap0[1]), 64'h0001_FFFC);

    // test 4: test 1 with ce toggling
    toggle_mode = 1'b1;
    for (int i = 0; i < 4; i++) cap0[i] = '0;
    run_burst(16'd3, 3, 1'b0, 16'd1);
    toggle_mode = 1'b0;
    check("t4_c0", 64'(cap0[0]), 64'd3);
    check("t4_c3", 64'(cap0[3]), 64'd12);

    // acc_len=0 behaves as 1: every frame emitted as the raw sample
    acc_len = 16'd0;
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 4; c++) sample(16'(c + 5 + f), (f == 0) && (c == 0));
    check("len1_c2", 64'(cap0[2]), 64'd7);

    // test 5: resync at chan 2 of frame 1, then a fresh 3-frame run
    acc_len = 16'd3;
    for (int c = 0; c < 4; c++) sample(16'(c + 1), c == 0);
    sample(16'd1, 1'b0);
    sample(16'd2, 1'b0);
    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 4; c++) sample(16'(c + 11), (f == 0) && (c == 0));
    sample(16'd0, 1'b0);
    idle(3);
    check("t5_c0", 64'(cap0[0]), 64'd33);
    check("t5_c3", 64'(cap0[3]), 64'd42);

    // test 6: one-cycle reset mid-frame, ignored samples, then a normal burst
    acc_len = 16'd3;
    for (int c = 0; c < 4; c++) sample(16'(c + 1), c == 0);
    sample(16'd9, 1'b0);
    do_reset(1);
    @(negedge clk);
    check("t6_rst_dout", 64'(d0), 64'd0);
    check("t6_rst_vld", 64'(vld0), 64'd0);
    for (int i = 0; i < 8; i++) sample(16'(i + 3), 1'b0);
    idle(3);
    run_burst(16'd3, 3, 1'b0, 16'd1);
    check("t6_c1", 64'(cap0[1]), 64'd6);
    check("t6_c3", 64'(cap0[3]), 64'd12);

    idle(4);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
